// File: rtl/imem_uart_loader_pkg.sv
// Shared types and defaults for the serial instruction-memory loader.
// Holds the loader and receiver state enums, bit timing and frame marker.
package imem_uart_loader_pkg;

  localparam int unsigned ClksPerBitDefault = 521;  // 5 MHz / 9600 baud
  localparam int unsigned AddrWDefault      = 7;
  localparam logic [7:0]  HdrByteDefault    = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StGetN,
    StGetData,
    StGetCsum,
    StDone,
    StError
  } loader_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // Largest word count whose last word address still fits in addr_w bits.
  function automatic int unsigned max_words(input int unsigned addr_w);
    return 32'd1 << (addr_w - 2);
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the loader.
interface imem_uart_loader_if #(
  parameter int unsigned AddrW = 7
) ();
  logic             we;
  logic [AddrW-1:0] addr;
  logic [31:0]      wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input we, input addr, input wdata);
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid on a good stop bit and frame_err on a low stop bit.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned ClksPerBit = ClksPerBitDefault
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned    CntW     = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(ClksPerBit - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            valid_q;
  logic            ferr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (prev_q && !sync2_q) state_q <= RxStart;
        end
        RxStart: begin
          // Re-check the start bit at its centre to reject glitches.
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            state_q <= sync2_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == FullLast) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == FullLast) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (sync2_q) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Serial program loader: parses A5/N/data/checksum frames from the UART and
// writes big-endian 32-bit words into instruction memory, holding the CPU meanwhile.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned ClksPerBit = ClksPerBitDefault,
  parameter int unsigned AddrW      = AddrWDefault,
  parameter logic [7:0]  HdrByte    = HdrByteDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                uart_rx_i,
  imem_uart_loader_if.master  imem,
  output logic                cpu_hold_o,
  output logic                load_done_o,
  output logic                load_err_o
);

  localparam int unsigned MaxWords = max_words(AddrW);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_byte #(
    .ClksPerBit(ClksPerBit)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  loader_state_e    state_q;
  logic [7:0]       words_left_q;
  logic [1:0]       byte_idx_q;
  logic [7:0]       csum_q;
  logic [23:0]      word_q;
  logic [AddrW-1:0] addr_q;
  logic [AddrW-1:0] imem_addr_q;
  logic [31:0]      imem_wdata_q;
  logic             imem_we_q;
  logic             hold_q;
  logic             done_q;
  logic             err_q;
  logic             n_ok;

  assign n_ok = (rx_byte != 8'd0) && (32'(rx_byte) <= MaxWords);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_we_q    <= 1'b0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid && rx_byte == HdrByte) begin
            state_q <= StGetN;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        StGetN: begin
          if (rx_ferr || (rx_valid && !n_ok)) begin
            state_q <= StError;
            hold_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            words_left_q <= rx_byte;
            addr_q       <= '0;
            csum_q       <= '0;
            byte_idx_q   <= '0;
            state_q      <= StGetData;
          end
        end
        StGetData: begin
          if (rx_ferr) begin
            state_q <= StError;
            hold_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            csum_q     <= csum_q ^ rx_byte;
            word_q     <= {word_q[15:0], rx_byte};
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= addr_q;
              imem_wdata_q <= {word_q, rx_byte};
              addr_q       <= addr_q + AddrW'(4);
              words_left_q <= words_left_q - 1'b1;
              if (words_left_q == 8'd1) state_q <= StGetCsum;
            end
          end
        end
        StGetCsum: begin
          if (rx_ferr || (rx_valid && rx_byte != csum_q)) begin
            state_q <= StError;
            hold_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            state_q <= StDone;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StError: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem.we     = imem_we_q;
  assign imem.addr   = imem_addr_q;
  assign imem.wdata  = imem_wdata_q;
  assign cpu_hold_o  = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomised and directed frame stimulus with a write scoreboard for imem_uart_loader.
`timescale 1ns/1ps
module tb_imem_uart_loader;

  localparam int unsigned Cpb   = 16;
  localparam int unsigned AddrW = 7;
  localparam int unsigned MaxN  = 32;

  typedef struct {
    logic [AddrW-1:0] addr;
    logic [31:0]      data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic hold, done, err;

  int total = 0;
  int bad = 0;
  wr_t exp_q[$];
  logic [7:0] payload[$];

  imem_uart_loader_if #(.AddrW(AddrW)) imem_bus ();

  imem_uart_loader #(
    .ClksPerBit(Cpb),
    .AddrW     (AddrW),
    .HdrByte   (8'hA5)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .uart_rx_i  (rx),
    .imem       (imem_bus),
    .cpu_hold_o (hold),
    .load_done_o(done),
    .load_err_o (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {25'd0, imem_bus.addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {25'd0, imem_bus.addr}, {25'd0, e.addr});
        check("write_data", imem_bus.wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sends A5, n_field, payload, checksum. cs_force replaces the true checksum;
  // ferr_idx >= 0 sends that payload byte with a low stop bit and ends the frame.
  task automatic send_frame(input logic [7:0] n_field, input bit cs_force,
                            input logic [7:0] cs_val, input int ferr_idx);
    logic [7:0] cs;
    bit n_ok, exp_done;
    n_ok = (n_field != 0) && (int'(n_field) <= MaxN);
    cs = 8'h00;
    foreach (payload[i]) cs ^= payload[i];
    exp_done = 1'b0;
    send_byte(8'hA5, 1'b1);
    send_byte(n_field, 1'b1);
    check("hold_after_n", {31'd0, hold}, {31'd0, n_ok});
    if (n_ok) begin
      bit aborted;
      aborted = 1'b0;
      for (int i = 0; i < payload.size(); i++) begin
        if (i == ferr_idx) begin
          send_byte(payload[i], 1'b0);
          aborted = 1'b1;
          break;
        end
        if (i % 4 == 3) begin
          wr_t w;
          w.addr = AddrW'(4 * (i / 4));
          w.data = {payload[i-3], payload[i-2], payload[i-1], payload[i]};
          exp_q.push_back(w);
        end
        send_byte(payload[i], 1'b1);
      end
      if (!aborted) begin
        logic [7:0] sent;
        sent = cs_force ? cs_val : cs;
        exp_done = (sent == cs);
        send_byte(sent, 1'b1);
      end
    end
    repeat (3 * Cpb) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
    check("load_done", {31'd0, done}, {31'd0, exp_done});
    check("load_err", {31'd0, err}, {31'd0, !exp_done});
    check("hold_end", {31'd0, hold}, 32'd0);
    exp_q.delete();
  endtask

  task automatic load_directed();
    payload.delete();
    payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_we", {31'd0, imem_bus.we}, 32'd0);
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", {25'd0, imem_bus.addr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Good two-word load; checksum is the XOR of the eight data bytes.
    load_directed();
    send_frame(8'd2, 1'b0, 8'h00, -1);

    // Reset in idle clears the sticky flags immediately.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_we", {31'd0, imem_bus.we}, 32'd0);
    check("async_rst_hold", {31'd0, hold}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Bad checksum: writes still happen, then error.
    load_directed();
    send_frame(8'd2, 1'b1, 8'h00, -1);

    // Bad counts.
    payload.delete();
    send_frame(8'h00, 1'b0, 8'h00, -1);
    send_frame(8'h21, 1'b0, 8'h00, -1);

    // Framing error on third data byte.
    load_directed();
    send_frame(8'd2, 1'b0, 8'h00, 2);

    // Short glitch in idle, then a good frame must still parse cleanly.
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb * 3 / 10) @(negedge clk);
    rx = 1'b1;
    repeat (Cpb) @(negedge clk);
    check("glitch_hold", {31'd0, hold}, 32'd0);
    load_directed();
    send_frame(8'd2, 1'b0, 8'h00, -1);

    // Reset part-way through data; no write may appear.
    send_byte(8'hA5, 1'b1);
    send_byte(8'd2, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("hold_mid_load", {31'd0, hold}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_hold", {31'd0, hold}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    load_directed();
    send_frame(8'd2, 1'b0, 8'h00, -1);

    // Randomised frames.
    for (int r = 0; r < 6; r++) begin
      int n, mode;
      logic [7:0] cs;
      n = $urandom_range(1, 4);
      mode = $urandom_range(0, 3);
      payload.delete();
      cs = 8'h00;
      for (int j = 0; j < 4 * n; j++) begin
        payload.push_back(8'($urandom_range(0, 255)));
        cs ^= payload[j];
      end
      case (mode)
        2: send_frame(8'(n), 1'b1, cs ^ 8'($urandom_range(1, 255)), -1);
        3: send_frame(8'(n), 1'b0, 8'h00, $urandom_range(0, 4 * n - 1));
        default: send_frame(8'(n), 1'b0, 8'h00, -1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
